// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with runtime baud, parity, stop-bit and length selection.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote over ticks 7, 8 and 9.

module uart_rx #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       rx,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic [7:0] data_out,
    output logic       rx_active,
    output logic       rx_done,
    output logic       parity_error,
    output logic       framing_error
);

    localparam int DIV_2400  = CLK_FREQ / (2400 * 16);
    localparam int DIV_4800  = CLK_FREQ / (4800 * 16);
    localparam int DIV_9600  = CLK_FREQ / (9600 * 16);
    localparam int DIV_19200 = CLK_FREQ / (19200 * 16);
    localparam int DIV_W     = $clog2(DIV_2400 + 1);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DECIDE_IDX = 4'd9;
`else
    localparam logic [3:0] DECIDE_IDX = 4'd7;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_HIGH
    } state_t;

    state_t state, state_next;

    logic             rx_meta, rx_s, rx_prev;
    logic [1:0]       cfg_baud, cfg_parity;
    logic             cfg_stop2, cfg_len8;
    logic [DIV_W-1:0] div_cnt, div_last;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg, data_word;
    logic             stop_err, par_err;
    logic             start_edge, in_frame, tick, sample_now, bit_val;
    logic             parity_en, last_bit, exp_par, finish;

`ifdef UART_RX_MAJORITY_EN
    logic samp7, samp8;
    assign bit_val = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_comb begin
        div_last = DIV_W'(DIV_9600 - 1);
        case (cfg_baud)
            2'b00: div_last = DIV_W'(DIV_2400 - 1);
            2'b01: div_last = DIV_W'(DIV_4800 - 1);
            2'b10: div_last = DIV_W'(DIV_9600 - 1);
            2'b11: div_last = DIV_W'(DIV_19200 - 1);
        endcase
    end

    // Tick index keeps running across bit boundaries, so every bit is sampled at the same index.
    assign start_edge = rx_prev & ~rx_s;
    assign in_frame   = (state == START) || (state == DATA) || (state == PARITY) ||
                        (state == STOP1) || (state == STOP2);
    assign tick       = in_frame && (div_cnt == div_last);
    assign sample_now = tick && (tick_cnt == DECIDE_IDX);
    assign parity_en  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    assign last_bit   = (bit_cnt == (cfg_len8 ? 3'd7 : 3'd6));
    assign data_word  = cfg_len8 ? shreg : {1'b0, shreg[7:1]};
    assign exp_par    = (cfg_parity == 2'b01) ? ~(^data_word) : ^data_word;
    assign rx_active  = in_frame;

    always_comb begin
        state_next = state;
        finish     = 1'b0;
        case (state)
            IDLE:      if (start_edge) state_next = START;
            START:     if (sample_now) state_next = bit_val ? IDLE : DATA;
            DATA:      if (sample_now && last_bit) state_next = parity_en ? PARITY : STOP1;
            PARITY:    if (sample_now) state_next = STOP1;
            STOP1: begin
                if (sample_now) begin
                    if (cfg_stop2) begin
                        state_next = STOP2;
                    end else begin
                        finish     = 1'b1;
                        state_next = rx_s ? IDLE : WAIT_HIGH;
                    end
                end
            end
            STOP2: begin
                if (sample_now) begin
                    finish     = 1'b1;
                    state_next = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= IDLE;
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            state   <= state_next;
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Results are registered from the final stop sample, so they appear one cycle later with rx_done.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cfg_baud      <= '0;
            cfg_parity    <= '0;
            cfg_stop2     <= 1'b0;
            cfg_len8      <= 1'b0;
            div_cnt       <= '0;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            stop_err      <= 1'b0;
            par_err       <= 1'b0;
            data_out      <= '0;
            rx_done       <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            samp7         <= 1'b0;
            samp8         <= 1'b0;
`endif
        end else begin
            rx_done <= finish;
            if (state == IDLE && start_edge) begin
                cfg_baud   <= baud_rate;
                cfg_parity <= parity_type;
                cfg_stop2  <= stop_bits;
                cfg_len8   <= data_length;
                div_cnt    <= '0;
                tick_cnt   <= '0;
                bit_cnt    <= '0;
                shreg      <= '0;
                stop_err   <= 1'b0;
                par_err    <= 1'b0;
            end else if (in_frame) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) tick_cnt <= tick_cnt + 4'd1;
            end else begin
                div_cnt  <= '0;
                tick_cnt <= '0;
            end
`ifdef UART_RX_MAJORITY_EN
            if (tick && tick_cnt == 4'd7) samp7 <= rx_s;
            if (tick && tick_cnt == 4'd8) samp8 <= rx_s;
`endif
            if (sample_now) begin
                case (state)
                    DATA: begin
                        shreg   <= {bit_val, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_err <= (bit_val != exp_par);
                    STOP1:   if (!bit_val) stop_err <= 1'b1;
                    default: ;
                endcase
            end
            if (finish) begin
                data_out      <= data_word;
                parity_error  <= par_err;
                framing_error <= stop_err | ~bit_val;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames bit by bit and compares each rx_done result with expectations
// derived from the frame contents; a reduced CLK_FREQ keeps bit periods short.

module tb_uart_rx;

    localparam int CLK_FREQ = 1843200;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] baud_rate = 2'b10;
    logic [1:0] parity_type = 2'b00;
    logic       stop_bits = 1'b0;
    logic       data_length = 1'b1;
    logic [7:0] data_out;
    logic       rx_active, rx_done, parity_error, framing_error;

    int          total = 0;
    int          bad = 0;
    logic [10:0] done_q[$];
    logic [7:0]  last_data = 8'h00;

    uart_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk(clk),
        .arst_n(arst_n),
        .rx(rx),
        .baud_rate(baud_rate),
        .parity_type(parity_type),
        .stop_bits(stop_bits),
        .data_length(data_length),
        .data_out(data_out),
        .rx_active(rx_active),
        .rx_done(rx_done),
        .parity_error(parity_error),
        .framing_error(framing_error)
    );

    always #5 clk = ~clk;

    // Every cycle of rx_done is logged, so a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (rx_done) done_q.push_back({rx_active, parity_error, framing_error, data_out});
    end

    initial begin
        repeat (150000) @(negedge clk);
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int bit_clks(input logic [1:0] b);
        return 16 * (CLK_FREQ / ((2400 << b) * 16));
    endfunction

    task automatic hold_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Config inputs are scrambled after the start bit; the receiver must ignore them mid-frame.
    task automatic apply_stimulus(input logic [7:0] data, input logic [1:0] b, input logic [1:0] par,
                                  input logic two, input logic len8, input logic flip,
                                  input logic s1, input logic s2);
        int         n = bit_clks(b);
        int         nb = len8 ? 8 : 7;
        logic [7:0] w;
        int         ones;
        logic       pbit;
        baud_rate   = b;
        parity_type = par;
        stop_bits   = two;
        data_length = len8;
        w    = len8 ? data : {1'b0, data[6:0]};
        ones = $countones(w);
        hold_bit(1'b0, n);
        baud_rate   = 2'($urandom);
        parity_type = 2'($urandom);
        stop_bits   = 1'($urandom);
        data_length = 1'($urandom);
        for (int i = 0; i < nb; i++) hold_bit(w[i], n);
        if (par == 2'b01 || par == 2'b10) begin
            pbit = (par == 2'b10) ? 1'(ones % 2) : 1'(1 - ones % 2);
            hold_bit(pbit ^ flip, n);
        end
        hold_bit(s1, n);
        if (two) hold_bit(s2, n);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp_data, input logic exp_pe,
                               input logic exp_fe, input int remain);
        int          t = 0;
        logic [10:0] e;
        while (done_q.size() == 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check_output({tag, " done"}, 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
            e = done_q.pop_front();
            check_output({tag, " data"}, 32'(e[7:0]), 32'(exp_data));
            check_output({tag, " parity"}, 32'(e[9]), 32'(exp_pe));
            check_output({tag, " framing"}, 32'(e[8]), 32'(exp_fe));
            check_output({tag, " active_at_done"}, 32'(e[10]), 32'd0);
        end
        check_output({tag, " pulses"}, 32'(done_q.size()), 32'(remain));
        last_data = exp_data;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] data, input logic [1:0] b,
                             input logic [1:0] par, input logic two, input logic len8,
                             input logic flip, input logic s1, input logic s2);
        logic [7:0] ed  = len8 ? data : {1'b0, data[6:0]};
        logic       epe = (par == 2'b01 || par == 2'b10) && flip;
        logic       efe = !s1 || (two && !s2);
        apply_stimulus(data, b, par, two, len8, flip, s1, s2);
        check_frame(tag, ed, epe, efe, 0);
    endtask

    initial begin
        logic [7:0] rd;
        logic [1:0] rb, rp;
        logic       r2, rl, rf, rs1, rs2;

        $display("[TB] uart_rx bench starting");
        repeat (5) @(negedge clk);
        check_output("reset data_out", 32'(data_out), 32'h0);
        check_output("reset rx_active", 32'(rx_active), 32'h0);
        check_output("reset rx_done", 32'(rx_done), 32'h0);
        check_output("reset parity_error", 32'(parity_error), 32'h0);
        check_output("reset framing_error", 32'(framing_error), 32'h0);
        arst_n = 1'b1;
        repeat (20) @(negedge clk);

        fork
            apply_stimulus(8'hA5, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            begin
                repeat (300) @(negedge clk);
                check_output("8N1 active mid-frame", 32'(rx_active), 32'd1);
            end
        join
        check_frame("8N1 A5", 8'hA5, 1'b0, 1'b0, 0);
        hold_bit(1'b1, 200);

        run_frame("7E1 good", 8'h55, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        hold_bit(1'b1, 200);
        run_frame("7E1 bad", 8'h55, 2'b11, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold_bit(1'b1, 200);

        apply_stimulus(8'h00, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_frame("8O2 stop2 low", 8'h00, 1'b0, 1'b1, 0);
        hold_bit(1'b0, 3 * bit_clks(2'b10));
        check_output("break rx_active", 32'(rx_active), 32'd0);
        check_output("break no done", 32'(done_q.size()), 32'd0);
        hold_bit(1'b1, 400);
        run_frame("8O2 3C", 8'h3C, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        hold_bit(1'b1, 200);

        baud_rate = 2'b10;
        rx = 1'b0;
        repeat (30) @(negedge clk);
        check_output("glitch active", 32'(rx_active), 32'd1);
        repeat (18) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check_output("glitch inactive", 32'(rx_active), 32'd0);
        check_output("glitch no done", 32'(done_q.size()), 32'd0);
        check_output("glitch data held", 32'(data_out), 32'(last_data));

        apply_stimulus(8'h12, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(8'h34, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_frame("b2b 12", 8'h12, 1'b0, 1'b0, 1);
        check_frame("b2b 34", 8'h34, 1'b0, 1'b0, 0);
        hold_bit(1'b1, 200);

        baud_rate   = 2'b10;
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        data_length = 1'b1;
        hold_bit(1'b0, bit_clks(2'b10));
        for (int i = 0; i < 3; i++) hold_bit(1'b1, bit_clks(2'b10));
        arst_n = 1'b0;
        #1;
        check_output("midframe reset data_out", 32'(data_out), 32'h0);
        check_output("midframe reset rx_active", 32'(rx_active), 32'h0);
        check_output("midframe reset rx_done", 32'(rx_done), 32'h0);
        check_output("midframe reset flags", 32'({parity_error, framing_error}), 32'h0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        arst_n = 1'b1;
        repeat (2 * bit_clks(2'b10)) @(negedge clk);
        check_output("midframe reset no done", 32'(done_q.size()), 32'd0);
        run_frame("after reset 81", 8'h81, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        hold_bit(1'b1, 200);

        for (int i = 0; i < 6; i++) begin
            rd  = 8'($urandom);
            rb  = 2'($urandom_range(1, 3));
            rp  = 2'($urandom);
            r2  = 1'($urandom);
            rl  = 1'($urandom);
            rf  = ($urandom_range(0, 3) == 0);
            rs1 = ($urandom_range(0, 4) != 0);
            rs2 = ($urandom_range(0, 4) != 0);
            run_frame($sformatf("random %0d", i), rd, rb, rp, r2, rl, rf, rs1, rs2);
            hold_bit(1'b1, 2 * bit_clks(rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's uart_tx.
- Takes the same runtime configuration as uart_tx: baud_rate, parity_type, stop_bits and data_length.
- Samples the serial line at 16x oversampling from its own internal tick divider.
- Deserializes LSB-first frames, checks parity and stop bits, and presents a parallel byte with a one-cycle done pulse.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; used to compute the oversample divisor.

Ports:
- clk  input  1  system clock
- arst_n  input  1  asynchronous active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- baud_rate  input  2  00=2400, 01=4800, 10=9600, 11=19200
- parity_type  input  2  00=none, 01=odd, 10=even, 11=none
- stop_bits  input  1  0=one stop bit, 1=two stop bits
- data_length  input  1  0=7 data bits, 1=8 data bits
- data_out  output  8  last received word; bit7 forced 0 in 7-bit mode
- rx_active  output  1  high while a frame is being received
- rx_done  output  1  one-cycle pulse when a frame completes
- parity_error  output  1  parity mismatch on the last frame
- framing_error  output  1  a stop bit was sampled low on the last frame

Behaviour:
- Reset behaviour: one clock domain, clk; reset is asynchronous and active-low on arst_n. Reset forces all outputs to 0, the FSM to IDLE and all counters to 0. An assertion mid-frame discards the frame and produces no rx_done.
- Input synchronization: rx passes through a 2-FF synchronizer (reset value 1). All logic uses the synchronized signal, rx_s.
- Tick generator:
  - divisor = CLK_FREQ/(baud*16), truncated; 9600 baud at 50 MHz gives 325.
  - One-cycle tick when the counter reaches divisor-1, then the counter wraps to 0.
  - The counter is held at 0 in IDLE and restarts on start detection.
- Config latch: baud_rate, parity_type, stop_bits and data_length are latched on start detection. Changes mid-frame have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
  - IDLE: a falling edge on rx_s (previous 1, current 0) goes to START; rx_active=1 the next cycle.
  - START: at tick count 7, i.e. the 8th tick (mid-bit):
    - rx_s=0: go to DATA.
    - rx_s=1: false start; go to IDLE with rx_active=0 and no rx_done.
  - DATA: sample every 16 ticks after the mid-start point; LSB first; 7 or 8 bits into a shift register. Then go to PARITY if parity is enabled, else STOP1.
  - PARITY: sample one bit. The expected bit gives odd (01) or even (10) total count of ones over data plus parity.
  - STOP1: sample. If stop_bits=1 go to STOP2, else complete.
  - STOP2: sample, then complete.
- Completion (the cycle after the final stop sample, i.e. mid stop bit):
  - rx_done=1 for exactly one cycle.
  - data_out, parity_error and framing_error are updated in that same cycle and hold until the next rx_done.
  - rx_active=0 in the same cycle.
  - Next state is IDLE if rx_s=1, else WAIT_HIGH.
  - parity_error is 0 when parity is none.
- WAIT_HIGH (break/low line): stay until rx_s=1, then go to IDLE. No new start is detected while the line stays low.
- Back-to-back frames: a falling edge arriving half a bit after the stop sample must be caught.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit value (start check, data, parity, stop) is the 2-of-3 majority of rx_s at ticks 7, 8 and 9 of the bit.
  - Decision timing moves 2 ticks later; rx_done occurs 2 ticks later than without the macro.
- Undefined: single sample at tick 7.
- Port list is identical in both builds.

Test Plan:
- 8N1 frame, 9600 baud, bit period 5200 clk, byte 0xA5 -> one rx_done pulse; data_out=0xA5; both error flags 0; rx_active high from the start edge to done.
- 7E1 frame, 19200 baud, data 0x55, parity bit 0 -> data_out=0x55; parity_error=0. Repeat with parity bit 1 -> parity_error=1, data_out=0x55.
- 8O2 frame, 0x00, parity 1, second stop bit driven 0 -> framing_error=1; FSM holds in WAIT_HIGH until rx returns high; the next valid frame 0x3C is received clean.
- Glitch: rx low for 4 tick periods at 9600 baud -> rx_active pulses, no rx_done, data_out unchanged.
- Two back-to-back 8N1 frames, 0x12 then 0x34, with no idle gap -> two rx_done pulses; data_out 0x12 then 0x34.
- arst_n asserted mid-DATA of 0xFF -> all outputs 0 immediately; no rx_done; after release the next 0x81 frame is received correctly.
